lcd_rx_monitor: RTL and testbench
=================================

Name: lcd_rx_monitor

Overview:
- Receive-side counterpart of the LCD colour-bar timing generator.
- Samples the generator's HD/VD/DEN/R/G/B on the system clock.
- Locks to frame timing, produces pixel coordinates and a registered pixel stream.
- At each frame boundary, reports line count, a frame checksum and timing-error flags.
- Sits on the generator's output bus, in benches and as an on-chip self-check.

Parameters:
H_ACTIVE, 800, expected DEN-high pixels per line
V_ACTIVE, 480, expected active lines per frame

Ports:
CLK  input  1  system clock; all sampling on rising edge
RST_n  input  1  asynchronous active-low reset
HD  input  1  horizontal sync, active low
VD  input  1  vertical sync, active low
DEN  input  1  data enable, active high
R  input  8  red
G  input  8  green
B  input  8  blue
PIX_VALID  output  1  registered DEN, qualified by lock
PIX_X  output  11  column of pixel on PIX_R/G/B
PIX_Y  output  10  line of pixel on PIX_R/G/B
PIX_R  output  8  registered R
PIX_G  output  8  registered G
PIX_B  output  8  registered B
LOCKED  output  1  high once the first VD falling edge has been seen
FRAME_DONE  output  1  one-cycle pulse at frame close
LINE_CNT  output  10  active lines in the last closed frame
FRAME_SUM  output  24  sum of {R,G,B} words over the last frame, mod 2^24
FRAME_CNT  output  16  closed-frame counter
ERR_H  output  1  some line in the last frame had length != H_ACTIVE
ERR_V  output  1  LINE_CNT != V_ACTIVE in the last frame

Behaviour:
Reset:
- Every output and internal register goes to 0.
- Previous-value registers HD_q and VD_q go to 1.
- State goes to IDLE.
- Reset mid-frame discards all partial data; the block must re-lock.

Edge detection:
- Falling edge = q==1 and current==0.
- DEN fall = DEN_q==1 and DEN==0.

State machine (2 states):
- IDLE: DEN and pixels ignored; PIX_VALID=0; no FRAME_DONE.
  - On VD fall: go to LOCKED; LOCKED output=1 next cycle; clear per-frame accumulators.
  - That VD fall produces no FRAME_DONE.
- LOCKED: stays here until reset.

Per-cycle operation in LOCKED:
- DEN=1:
  - Pixel outputs, one cycle later: PIX_VALID=1, PIX_X=x, PIX_Y=y, PIX_R/G/B = inputs.
  - Then x increments, saturating at 2047.
  - Accumulator acc += {R,G,B}, mod 2^24.
- DEN=0: PIX_VALID=0 next cycle; PIX_X/PIX_Y/PIX_R/G/B hold their values.
- DEN fall (end of a DEN run = one line):
  - If x != H_ACTIVE, set errh_acc.
  - y increments, saturating at 1023.
  - x resets to 0.
- HD fall: x resets to 0. A DEN run in progress continues counting from 0.
  - The generator never does this; the monitor must not hang if it happens.

Frame close (VD fall while LOCKED):
- Registered, visible the following cycle:
  - FRAME_DONE=1 for exactly one cycle.
  - LINE_CNT=y.
  - FRAME_SUM=acc.
  - ERR_H=errh_acc.
  - ERR_V=(y!=V_ACTIVE).
  - FRAME_CNT increments, wrapping at 2^16.
- x, y, acc and errh_acc cleared.
- Reported values hold until the next frame close.
- Line closed in the same cycle: if a DEN fall coincides with the VD fall, that line is counted and checked in the frame being closed.
- Pixel in the same cycle: if DEN=1 coincides with the VD fall, that pixel is pixel (0,0) of the new frame and is accumulated into the new acc.

Latency:
- Pixel path: 1 cycle.
- FRAME_DONE: 1 cycle after the sampled VD fall.

Arithmetic:
- All counters unsigned.
- acc is a 24-bit adder; carry is discarded.

Test Plan:
- Reset, then DEN pulses with no VD fall -> LOCKED=0, PIX_VALID stays 0, no FRAME_DONE.
- VD fall, 480 lines of 800 white pixels (FFFFFF), then VD fall -> one FRAME_DONE pulse; LINE_CNT=480, FRAME_SUM=0xFA2400, ERR_H=0, ERR_V=0, FRAME_CNT=1.
- Same frame, but line 100 has 799 pixels -> ERR_H=1, ERR_V=0, LINE_CNT=480.
- Frame with 479 lines, all 800 black pixels -> ERR_V=1, LINE_CNT=479, FRAME_SUM=0.
- Pixel-path check, DEN high with R=0x12 G=0x34 B=0x56 as the 3rd pixel of line 2 -> next cycle PIX_VALID=1, PIX_X=2, PIX_Y=2, PIX_R/G/B=12/34/56.
- RST_n low mid-line 200, then released -> all outputs 0; first following VD fall gives no FRAME_DONE; the second gives correct counts.

Source files
------------

// File: rtl/lcd_rx_monitor_if.sv
// Video bus between the LCD colour-bar timing generator and its receive-side
// monitor. The generator drives every signal; the monitor only samples.
interface lcd_rx_monitor_if;
    logic       HD;   // horizontal sync, active low
    logic       VD;   // vertical sync, active low
    logic       DEN;  // data enable, active high
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;

    modport master (output HD, VD, DEN, R, G, B);
    modport slave  (input  HD, VD, DEN, R, G, B);
endinterface

// File: rtl/lcd_rx_monitor.sv
// Receive-side monitor for the LCD colour-bar timing generator.
// Locks to the first VD falling edge, then tracks pixel coordinates,
// re-registers the pixel stream and, at every following VD fall, reports
// the line count, a 24-bit frame checksum and horizontal/vertical timing
// error flags for the frame that just closed.
module lcd_rx_monitor #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480
) (
    input  logic                CLK,
    input  logic                RST_n,
    lcd_rx_monitor_if.slave     bus,
    output logic                PIX_VALID,
    output logic [10:0]         PIX_X,
    output logic [9:0]          PIX_Y,
    output logic [7:0]          PIX_R,
    output logic [7:0]          PIX_G,
    output logic [7:0]          PIX_B,
    output logic                LOCKED,
    output logic                FRAME_DONE,
    output logic [9:0]          LINE_CNT,
    output logic [23:0]         FRAME_SUM,
    output logic [15:0]         FRAME_CNT,
    output logic                ERR_H,
    output logic                ERR_V
);

    localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACT = 10'(V_ACTIVE);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Column counter saturates so a runaway DEN cannot wrap back into range.
    function automatic logic [10:0] sat_inc_x(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    // Line counter saturates for the same reason.
    function automatic logic [9:0] sat_inc_y(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    state_t      state_q, state_d;
    logic        hd_q, hd_d;
    logic        vd_q, vd_d;
    logic        den_q, den_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [23:0] acc_q, acc_d;
    logic        errh_acc_q, errh_acc_d;

    logic        pix_valid_q, pix_valid_d;
    logic [10:0] pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic [7:0]  pix_r_q, pix_r_d;
    logic [7:0]  pix_g_q, pix_g_d;
    logic [7:0]  pix_b_q, pix_b_d;
    logic        locked_q, locked_d;
    logic        frame_done_q, frame_done_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic [23:0] frame_sum_q, frame_sum_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        err_h_q, err_h_d;
    logic        err_v_q, err_v_d;

    logic        hd_fall, vd_fall, den_fall;
    logic [9:0]  y_line;
    logic        errh_line;
    logic [10:0] x_base;
    logic [9:0]  y_base;
    logic [23:0] acc_base;
    logic        errh_base;

    assign hd_fall  = hd_q  & ~bus.HD;
    assign vd_fall  = vd_q  & ~bus.VD;
    assign den_fall = den_q & ~bus.DEN;

    // Next-state logic: line close first, then frame close, then the pixel,
    // so a coincident DEN fall belongs to the old frame and a coincident
    // DEN-high pixel becomes pixel (0,0) of the new one.
    always_comb begin
        state_d      = state_q;
        hd_d         = bus.HD;
        vd_d         = bus.VD;
        den_d        = bus.DEN;
        x_d          = x_q;
        y_d          = y_q;
        acc_d        = acc_q;
        errh_acc_d   = errh_acc_q;
        pix_valid_d  = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_r_d      = pix_r_q;
        pix_g_d      = pix_g_q;
        pix_b_d      = pix_b_q;
        locked_d     = locked_q;
        frame_done_d = 1'b0;
        line_cnt_d   = line_cnt_q;
        frame_sum_d  = frame_sum_q;
        frame_cnt_d  = frame_cnt_q;
        err_h_d      = err_h_q;
        err_v_d      = err_v_q;
        y_line       = y_q;
        errh_line    = errh_acc_q;
        x_base       = x_q;
        y_base       = y_q;
        acc_base     = acc_q;
        errh_base    = errh_acc_q;

        if (state_q == ST_IDLE) begin
            if (vd_fall) begin
                state_d    = ST_LOCKED;
                locked_d   = 1'b1;
                x_d        = '0;
                y_d        = '0;
                acc_d      = '0;
                errh_acc_d = 1'b0;
            end
        end else begin
            if (den_fall) begin
                if (x_q != H_ACT) begin
                    errh_line = 1'b1;
                end
                y_line = sat_inc_y(y_q);
            end

            x_base    = (den_fall || hd_fall || vd_fall) ? 11'd0 : x_q;
            y_base    = vd_fall ? 10'd0 : y_line;
            acc_base  = vd_fall ? 24'd0 : acc_q;
            errh_base = vd_fall ? 1'b0 : errh_line;

            if (vd_fall) begin
                frame_done_d = 1'b1;
                line_cnt_d   = y_line;
                frame_sum_d  = acc_q;
                err_h_d      = errh_line;
                err_v_d      = (y_line != V_ACT);
                frame_cnt_d  = frame_cnt_q + 16'd1;
            end

            x_d        = x_base;
            y_d        = y_base;
            acc_d      = acc_base;
            errh_acc_d = errh_base;

            if (bus.DEN) begin
                pix_valid_d = 1'b1;
                pix_x_d     = x_base;
                pix_y_d     = y_base;
                pix_r_d     = bus.R;
                pix_g_d     = bus.G;
                pix_b_d     = bus.B;
                x_d         = sat_inc_x(x_base);
                acc_d       = acc_base + {bus.R, bus.G, bus.B};
            end
        end
    end

    // State and all registered outputs; async reset drops everything and forces re-lock.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q      <= ST_IDLE;
            hd_q         <= 1'b1;
            vd_q         <= 1'b1;
            den_q        <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            acc_q        <= '0;
            errh_acc_q   <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_r_q      <= '0;
            pix_g_q      <= '0;
            pix_b_q      <= '0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            line_cnt_q   <= '0;
            frame_sum_q  <= '0;
            frame_cnt_q  <= '0;
            err_h_q      <= 1'b0;
            err_v_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hd_q         <= hd_d;
            vd_q         <= vd_d;
            den_q        <= den_d;
            x_q          <= x_d;
            y_q          <= y_d;
            acc_q        <= acc_d;
            errh_acc_q   <= errh_acc_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_r_q      <= pix_r_d;
            pix_g_q      <= pix_g_d;
            pix_b_q      <= pix_b_d;
            locked_q     <= locked_d;
            frame_done_q <= frame_done_d;
            line_cnt_q   <= line_cnt_d;
            frame_sum_q  <= frame_sum_d;
            frame_cnt_q  <= frame_cnt_d;
            err_h_q      <= err_h_d;
            err_v_q      <= err_v_d;
        end
    end

    assign PIX_VALID  = pix_valid_q;
    assign PIX_X      = pix_x_q;
    assign PIX_Y      = pix_y_q;
    assign PIX_R      = pix_r_q;
    assign PIX_G      = pix_g_q;
    assign PIX_B      = pix_b_q;
    assign LOCKED     = locked_q;
    assign FRAME_DONE = frame_done_q;
    assign LINE_CNT   = line_cnt_q;
    assign FRAME_SUM  = frame_sum_q;
    assign FRAME_CNT  = frame_cnt_q;
    assign ERR_H      = err_h_q;
    assign ERR_V      = err_v_q;

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// Directed bench for lcd_rx_monitor, run with a small 8x6 active raster so
// whole frames stay short. Inputs change on the falling clock edge and the
// outputs are checked on the following falling edge.
module tb_lcd_rx_monitor;

    localparam int HA = 8;
    localparam int VA = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_valid;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic        locked, frame_done;
    logic [9:0]  line_cnt;
    logic [23:0] frame_sum;
    logic [15:0] frame_cnt;
    logic        err_h, err_v;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int pv_cnt      = 0;
    int dc0;

    always #5 clk = ~clk;

    lcd_rx_monitor_if bus ();

    lcd_rx_monitor #(.H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
        .CLK        (clk),
        .RST_n      (rst_n),
        .bus        (bus),
        .PIX_VALID  (pix_valid),
        .PIX_X      (pix_x),
        .PIX_Y      (pix_y),
        .PIX_R      (pix_r),
        .PIX_G      (pix_g),
        .PIX_B      (pix_b),
        .LOCKED     (locked),
        .FRAME_DONE (frame_done),
        .LINE_CNT   (line_cnt),
        .FRAME_SUM  (frame_sum),
        .FRAME_CNT  (frame_cnt),
        .ERR_H      (err_h),
        .ERR_V      (err_v)
    );

    // Pulse counters sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (frame_done) done_cnt++;
        if (pix_valid)  pv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic hd, input logic vd, input logic den, input logic [23:0] rgb);
        bus.HD  = hd;
        bus.VD  = vd;
        bus.DEN = den;
        bus.R   = rgb[23:16];
        bus.G   = rgb[15:8];
        bus.B   = rgb[7:0];
        @(negedge clk);
    endtask

    // One DEN run of n pixels followed by a short blanking gap with an HD pulse.
    task automatic line(input int n, input logic [23:0] rgb);
        for (int i = 0; i < n; i++) apply(1'b1, 1'b1, 1'b1, rgb);
        apply(1'b0, 1'b1, 1'b0, 24'h0);
        apply(1'b1, 1'b1, 1'b0, 24'h0);
    endtask

    task automatic close_check(input string tag, input int lc, input logic [23:0] sum,
                               input logic eh, input logic ev, input int fc);
        apply(1'b1, 1'b0, 1'b0, 24'h0);
        chk({tag, "_done"},  32'(frame_done), 32'd1);
        chk({tag, "_lines"}, 32'(line_cnt),   32'(lc));
        chk({tag, "_sum"},   32'(frame_sum),  32'(sum));
        chk({tag, "_errh"},  32'(err_h),      32'(eh));
        chk({tag, "_errv"},  32'(err_v),      32'(ev));
        chk({tag, "_fcnt"},  32'(frame_cnt),  32'(fc));
        apply(1'b1, 1'b1, 1'b0, 24'h0);
        chk({tag, "_done_low"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        bus.HD = 1'b1; bus.VD = 1'b1; bus.DEN = 1'b0;
        bus.R = 8'h0; bus.G = 8'h0; bus.B = 8'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 1'b1, 1'b0, 24'h0);

        // Reset state
        chk("rst_locked", 32'(locked),     32'd0);
        chk("rst_pv",     32'(pix_valid),  32'd0);
        chk("rst_done",   32'(frame_done), 32'd0);
        chk("rst_fcnt",   32'(frame_cnt),  32'd0);
        chk("rst_lines",  32'(line_cnt),   32'd0);
        chk("rst_sum",    32'(frame_sum),  32'd0);

        // DEN activity before any VD fall is ignored
        line(HA, 24'hFFFFFF);
        line(HA, 24'hFFFFFF);
        chk("idle_locked", 32'(locked),   32'd0);
        chk("idle_pv",     32'(pv_cnt),   32'd0);
        chk("idle_done",   32'(done_cnt), 32'd0);

        // First VD fall locks without a FRAME_DONE
        apply(1'b1, 1'b0, 1'b0, 24'h0);
        chk("lock_locked", 32'(locked),     32'd1);
        chk("lock_done",   32'(frame_done), 32'd0);
        apply(1'b1, 1'b1, 1'b0, 24'h0);
        chk("lock_donecnt", 32'(done_cnt), 32'd0);

        // F1: 6 lines of 8 white pixels: 48 * 0xFFFFFF mod 2^24 = 0xFFFFD0
        for (int l = 0; l < VA; l++) line(HA, 24'hFFFFFF);
        close_check("f1", 6, 24'hFFFFD0, 1'b0, 1'b0, 1);
        chk("f1_donecnt", 32'(done_cnt), 32'd1);

        // F2: line 2 one pixel short: 47 white pixels -> 0xFFFFD1
        for (int l = 0; l < VA; l++) line((l == 2) ? HA - 1 : HA, 24'hFFFFFF);
        close_check("f2", 6, 24'hFFFFD1, 1'b1, 1'b0, 2);

        // F3: pixel-path check at (2,2), 5 black lines otherwise
        line(HA, 24'h0);
        line(HA, 24'h0);
        apply(1'b1, 1'b1, 1'b1, 24'h0);
        apply(1'b1, 1'b1, 1'b1, 24'h0);
        apply(1'b1, 1'b1, 1'b1, 24'h123456);
        chk("pix_valid", 32'(pix_valid), 32'd1);
        chk("pix_x",     32'(pix_x),     32'd2);
        chk("pix_y",     32'(pix_y),     32'd2);
        chk("pix_r",     32'(pix_r),     32'h12);
        chk("pix_g",     32'(pix_g),     32'h34);
        chk("pix_b",     32'(pix_b),     32'h56);
        for (int i = 3; i < HA; i++) apply(1'b1, 1'b1, 1'b1, 24'h0);
        apply(1'b0, 1'b1, 1'b0, 24'h0);
        chk("blank_pv",   32'(pix_valid), 32'd0);
        chk("blank_xhld", 32'(pix_x),     32'd7);
        chk("blank_yhld", 32'(pix_y),     32'd2);
        apply(1'b1, 1'b1, 1'b0, 24'h0);
        line(HA, 24'h0);
        line(HA, 24'h0);
        close_check("f3", 5, 24'h123456, 1'b0, 1'b1, 3);

        // F4: 5 black lines
        for (int l = 0; l < VA - 1; l++) line(HA, 24'h0);
        close_check("f4", 5, 24'h0, 1'b0, 1'b1, 4);

        // F5: last line's DEN fall coincides with the VD fall
        for (int l = 0; l < VA - 1; l++) line(HA, 24'hFFFFFF);
        for (int i = 0; i < HA; i++) apply(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        close_check("f5", 6, 24'hFFFFD0, 1'b0, 1'b0, 5);

        // F6: VD fall coincides with a DEN-high pixel, which opens F7 at (0,0)
        for (int l = 0; l < VA; l++) line(HA, 24'hFFFFFF);
        apply(1'b1, 1'b0, 1'b1, 24'h000001);
        chk("f6_done",  32'(frame_done), 32'd1);
        chk("f6_lines", 32'(line_cnt),   32'd6);
        chk("f6_sum",   32'(frame_sum),  32'hFFFFD0);
        chk("f6_fcnt",  32'(frame_cnt),  32'd6);
        chk("f6_pv",    32'(pix_valid),  32'd1);
        chk("f6_px",    32'(pix_x),      32'd0);
        chk("f6_py",    32'(pix_y),      32'd0);

        // F7: 48 pixels of value 1, first one taken at the VD fall
        line(HA - 1, 24'h000001);
        for (int l = 1; l < VA; l++) line(HA, 24'h000001);
        close_check("f7", 6, 24'h000030, 1'b0, 1'b0, 7);

        // F8: a 2050-pixel DEN run saturates the column at 2047
        for (int i = 0; i < 2050; i++) apply(1'b1, 1'b1, 1'b1, 24'h0);
        chk("xsat", 32'(pix_x), 32'd2047);
        apply(1'b1, 1'b1, 1'b0, 24'h0);
        for (int l = 1; l < VA; l++) line(HA, 24'h0);
        close_check("f8", 6, 24'h0, 1'b1, 1'b0, 8);

        // F9: 1030 one-pixel lines saturate the line count at 1023
        for (int l = 0; l < 1030; l++) line(1, 24'h0);
        close_check("f9", 1023, 24'h0, 1'b1, 1'b1, 9);

        // Reset in the middle of a line, then re-lock
        for (int l = 0; l < 3; l++) line(HA, 24'hFFFFFF);
        for (int i = 0; i < 4; i++) apply(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        rst_n = 1'b0;
        apply(1'b1, 1'b1, 1'b0, 24'h0);
        apply(1'b1, 1'b1, 1'b0, 24'h0);
        chk("mrst_locked", 32'(locked),    32'd0);
        chk("mrst_fcnt",   32'(frame_cnt), 32'd0);
        chk("mrst_lines",  32'(line_cnt),  32'd0);
        chk("mrst_sum",    32'(frame_sum), 32'd0);
        chk("mrst_errh",   32'(err_h),     32'd0);
        chk("mrst_errv",   32'(err_v),     32'd0);
        chk("mrst_pv",     32'(pix_valid), 32'd0);
        chk("mrst_px",     32'(pix_x),     32'd0);
        chk("mrst_pr",     32'(pix_r),     32'd0);
        rst_n = 1'b1;
        apply(1'b1, 1'b1, 1'b0, 24'h0);
        dc0 = done_cnt;
        apply(1'b1, 1'b0, 1'b0, 24'h0);
        chk("relock_locked", 32'(locked),     32'd1);
        chk("relock_done",   32'(frame_done), 32'd0);
        apply(1'b1, 1'b1, 1'b0, 24'h0);
        chk("relock_donecnt", 32'(done_cnt), 32'(dc0));
        for (int l = 0; l < VA; l++) line(HA, 24'hFFFFFF);
        close_check("f10", 6, 24'hFFFFD0, 1'b0, 1'b0, 1);
        chk("f10_donecnt", 32'(done_cnt), 32'(dc0 + 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
